shreg_seq: RTL and testbench

SHREG_SEQ -- requirements
Module: shreg_seq

---
 rtl/shreg_seq_pkg.sv | 33 +++
 rtl/shreg_seq_rr.sv | 76 +++++++
 rtl/shreg_seq.sv | 121 ++++++++++++
 tb/tb_shreg_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shreg_seq_pkg.sv
// ============================================================================
// Module   : shreg_seq_pkg
// Purpose  : Shared state encoding, pointer type and width constants for the
//            shreg_seq shift-register sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shreg_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        PTR_A = 1'b0,
        PTR_B = 1'b1
    } rr_ptr_t;

    // Terminal shift count for a transfer of the given length.
    function automatic logic [CNT_W-1:0] last_cnt(input int width);
        return CNT_W'(width - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shreg_seq_rr.sv
// ============================================================================
// Module   : shreg_seq_rr
// Purpose  : Two-way round-robin arbiter; latches the grant pair and advances
//            the fairness pointer when a transfer completes.
//            Optional macro SHREG_SEQ_BOTH_EN: simultaneous requests grant both.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shreg_seq_rr
    import shreg_seq_pkg::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_arb,
    input  logic i_update,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    rr_ptr_t ptr_q, ptr_d;
    logic    gnt_a_q, gnt_a_d;
    logic    gnt_b_q, gnt_b_d;
    logic    pick_a;
    logic    pick_b;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr_q   <= PTR_A;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
        end
    end

    always_comb begin
`ifdef SHREG_SEQ_BOTH_EN
        // Both requesters run in lockstep, so there is no tie to break.
        pick_a = i_req_a;
        pick_b = i_req_b;
`else
        pick_a = i_req_a && !(i_req_b && (ptr_q == PTR_B));
        pick_b = i_req_b && !(i_req_a && (ptr_q == PTR_A));
`endif
    end

    always_comb begin
        ptr_d   = ptr_q;
        gnt_a_d = gnt_a_q;
        gnt_b_d = gnt_b_q;
        if (i_arb) begin
            gnt_a_d = pick_a;
            gnt_b_d = pick_b;
        end else if (i_update) begin
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            // A lockstep transfer served both channels and leaves the pointer alone.
            if (gnt_a_q && !gnt_b_q) begin
                ptr_d = PTR_B;
            end else if (gnt_b_q && !gnt_a_q) begin
                ptr_d = PTR_A;
            end
        end
    end

    assign o_gnt_a = gnt_a_q;
    assign o_gnt_b = gnt_b_q;

endmodule

`default_nettype wire

// File: rtl/shreg_seq.sv
// ============================================================================
// Module   : shreg_seq
// Purpose  : Sequencer sharing one shift register between two requesters:
//            IDLE -> LOAD -> SHIFT x WIDTH -> DONE, round-robin arbitrated.
//            Optional macro SHREG_SEQ_BOTH_EN: lockstep dual-channel transfers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shreg_seq
    import shreg_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             REQ_A,
    input  logic             REQ_B,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             ASEL,
    output logic             BSEL,
    output logic             ACLK_EN,
    output logic             BCLK_EN,
    output logic             DONE_A,
    output logic             DONE_B,
    output logic             BUSY,
    output logic [CNT_W-1:0] CNT
);

    localparam logic [CNT_W-1:0] CNT_LAST = last_cnt(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arb_en;
    logic             rr_update;
    logic             gnt_a;
    logic             gnt_b;
    logic             load_ph;
    logic             shift_ph;
    logic             done_ph;

    shreg_seq_rr u_rr (
        .clk      (CLK),
        .clr_n    (CLR_N),
        .i_req_a  (REQ_A),
        .i_req_b  (REQ_B),
        .i_arb    (arb_en),
        .i_update (rr_update),
        .o_gnt_a  (gnt_a),
        .o_gnt_b  (gnt_b)
    );

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arb_en    = 1'b0;
        rr_update = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (REQ_A || REQ_B) begin
                    state_d = ST_LOAD;
                    arb_en  = 1'b1;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Always pass through IDLE so a held request is re-arbitrated.
                cnt_d     = '0;
                state_d   = ST_IDLE;
                rr_update = 1'b1;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        load_ph  = (state_q == ST_LOAD);
        shift_ph = (state_q == ST_SHIFT);
        done_ph  = (state_q == ST_DONE);
        GNT_A    = gnt_a;
        GNT_B    = gnt_b;
        ASEL     = gnt_a && load_ph;
        BSEL     = gnt_b && load_ph;
        ACLK_EN  = gnt_a && (load_ph || shift_ph);
        BCLK_EN  = gnt_b && (load_ph || shift_ph);
        DONE_A   = gnt_a && done_ph;
        DONE_B   = gnt_b && done_ph;
        BUSY     = (state_q != ST_IDLE);
        CNT      = cnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_shreg_seq.sv
// ============================================================================
// Module   : tb_shreg_seq
// Purpose  : Directed self-checking bench for shreg_seq (WIDTH=8 and WIDTH=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shreg_seq;

    localparam int CH_NONE  = 0;
    localparam int CH_A     = 1;
    localparam int CH_B     = 2;
    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_SHIFT = 2;
    localparam int PH_DONE  = 3;

    logic       CLK;
    logic       CLR_N;
    logic       REQ_A;
    logic       REQ_B;
    logic       w2_req_a;
    logic       w2_req_b;

    logic       gnt_a, gnt_b, asel, bsel, aclk_en, bclk_en, done_a, done_b, busy;
    logic [3:0] cnt;
    logic       w2_gnt_a, w2_gnt_b, w2_asel, w2_bsel, w2_aclk_en, w2_bclk_en;
    logic       w2_done_a, w2_done_b, w2_busy;
    logic [3:0] w2_cnt;

    logic [12:0] obs8;
    logic [12:0] obs2;

    int checks = 0;
    int errors = 0;

    shreg_seq #(.WIDTH(8)) u_dut (
        .CLK     (CLK),
        .CLR_N   (CLR_N),
        .REQ_A   (REQ_A),
        .REQ_B   (REQ_B),
        .GNT_A   (gnt_a),
        .GNT_B   (gnt_b),
        .ASEL    (asel),
        .BSEL    (bsel),
        .ACLK_EN (aclk_en),
        .BCLK_EN (bclk_en),
        .DONE_A  (done_a),
        .DONE_B  (done_b),
        .BUSY    (busy),
        .CNT     (cnt)
    );

    shreg_seq #(.WIDTH(2)) u_dut_w2 (
        .CLK     (CLK),
        .CLR_N   (CLR_N),
        .REQ_A   (w2_req_a),
        .REQ_B   (w2_req_b),
        .GNT_A   (w2_gnt_a),
        .GNT_B   (w2_gnt_b),
        .ASEL    (w2_asel),
        .BSEL    (w2_bsel),
        .ACLK_EN (w2_aclk_en),
        .BCLK_EN (w2_bclk_en),
        .DONE_A  (w2_done_a),
        .DONE_B  (w2_done_b),
        .BUSY    (w2_busy),
        .CNT     (w2_cnt)
    );

    assign obs8 = {gnt_a, gnt_b, asel, bsel, aclk_en, bclk_en, done_a, done_b, busy, cnt};
    assign obs2 = {w2_gnt_a, w2_gnt_b, w2_asel, w2_bsel, w2_aclk_en, w2_bclk_en,
                   w2_done_a, w2_done_b, w2_busy, w2_cnt};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected output vector for a channel in a given phase.
    function automatic logic [12:0] exp_out(input int ch, input int ph, input int c);
        logic a;
        logic b;
        logic [3:0] cv;
        a  = (ph != PH_IDLE) && (ch == CH_A);
        b  = (ph != PH_IDLE) && (ch == CH_B);
        cv = 4'(c);
        return {a, b,
                a && (ph == PH_LOAD), b && (ph == PH_LOAD),
                a && (ph == PH_LOAD || ph == PH_SHIFT), b && (ph == PH_LOAD || ph == PH_SHIFT),
                a && (ph == PH_DONE), b && (ph == PH_DONE),
                ph != PH_IDLE, cv};
    endfunction

    task automatic chk(input string tag, input int idx, input logic [12:0] obs,
                       input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    // One full WIDTH=8 transfer, starting from an IDLE negedge with a request set.
    task automatic run_xfer8(input string tag, input int ch, input int drop_at);
        @(negedge CLK);
        chk({tag, "_load"}, 0, obs8, exp_out(ch, PH_LOAD, 0));
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk({tag, "_shift"}, i, obs8, exp_out(ch, PH_SHIFT, i));
            if (i == drop_at) begin
                REQ_A = 1'b0;
                REQ_B = 1'b0;
            end
        end
        @(negedge CLK);
        chk({tag, "_done"}, 0, obs8, exp_out(ch, PH_DONE, 0));
    endtask

    initial begin
        CLR_N    = 1'b0;
        REQ_A    = 1'b0;
        REQ_B    = 1'b0;
        w2_req_a = 1'b0;
        w2_req_b = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("reset", 0, obs8, 13'h0);
        chk("reset_w2", 0, obs2, 13'h0);
        CLR_N = 1'b1;
        @(negedge CLK);
        chk("idle_no_req", 0, obs8, exp_out(CH_NONE, PH_IDLE, 0));

        // Single requester A
        REQ_A = 1'b1;
        run_xfer8("a_only", CH_A, -1);
        REQ_A = 1'b0;
        @(negedge CLK);
        chk("a_only_idle", 0, obs8, exp_out(CH_NONE, PH_IDLE, 0));

        // Round robin after reset: A, B, A with one IDLE cycle between
        CLR_N = 1'b0;
        #1;
        chk("rr_reset", 0, obs8, 13'h0);
        @(negedge CLK);
        CLR_N = 1'b1;
        REQ_A = 1'b1;
        REQ_B = 1'b1;
        run_xfer8("rr1", CH_A, -1);
        @(negedge CLK);
        chk("rr_gap1", 0, obs8, exp_out(CH_NONE, PH_IDLE, 0));
        run_xfer8("rr2", CH_B, -1);
        @(negedge CLK);
        chk("rr_gap2", 0, obs8, exp_out(CH_NONE, PH_IDLE, 0));
        run_xfer8("rr3", CH_A, -1);
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        @(negedge CLK);
        chk("rr_idle", 0, obs8, exp_out(CH_NONE, PH_IDLE, 0));

        // REQ_B dropped on SHIFT cycle 3 still completes
        REQ_B = 1'b1;
        run_xfer8("b_drop", CH_B, 3);
        @(negedge CLK);
        chk("b_drop_idle", 0, obs8, exp_out(CH_NONE, PH_IDLE, 0));

        // Asynchronous abort at CNT=4, then restart
        REQ_B = 1'b1;
        @(negedge CLK);
        chk("abort_load", 0, obs8, exp_out(CH_B, PH_LOAD, 0));
        for (int i = 0; i <= 4; i++) begin
            @(negedge CLK);
            chk("abort_shift", i, obs8, exp_out(CH_B, PH_SHIFT, i));
        end
        #2;
        CLR_N = 1'b0;
        #1;
        chk("abort_async", 0, obs8, 13'h0);
        @(negedge CLK);
        chk("abort_hold", 0, obs8, 13'h0);
        CLR_N = 1'b1;
        run_xfer8("restart", CH_B, -1);
        REQ_B = 1'b0;
        @(negedge CLK);
        chk("restart_idle", 0, obs8, exp_out(CH_NONE, PH_IDLE, 0));

        // WIDTH=2 instance: LOAD, two SHIFT cycles, DONE
        w2_req_a = 1'b1;
        @(negedge CLK);
        chk("w2_load", 0, obs2, exp_out(CH_A, PH_LOAD, 0));
        @(negedge CLK);
        chk("w2_shift", 0, obs2, exp_out(CH_A, PH_SHIFT, 0));
        @(negedge CLK);
        chk("w2_shift", 1, obs2, exp_out(CH_A, PH_SHIFT, 1));
        @(negedge CLK);
        chk("w2_done", 0, obs2, exp_out(CH_A, PH_DONE, 0));
        w2_req_a = 1'b0;
        @(negedge CLK);
        chk("w2_idle", 0, obs2, exp_out(CH_NONE, PH_IDLE, 0));
        chk("w8_quiet", 0, obs8, exp_out(CH_NONE, PH_IDLE, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
